echo_detector: RTL and testbench

ECHO_DETECTOR -- requirements
Module: echo_detector

---
 rtl/echo_detector_pkg.sv | 15 +
 rtl/echo_detector_if.sv | 31 +++
 rtl/echo_detector_sample_counter.sv | 25 ++
 rtl/echo_detector.sv | 142 ++++++++++++++
 tb/tb_echo_detector.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/echo_detector_pkg.sv
// rtl/echo_detector_pkg.sv - shared constants and FSM state encoding for the echo detector
package echo_detector_pkg;

    localparam int DEF_N_BITS   = 32;
    localparam int DEF_CNT_BITS = 24;
    localparam int BLANK_BITS   = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BLANK  = 2'd1,
        ST_SEARCH = 2'd2,
        ST_TRACK  = 2'd3
    } state_t;

endpackage

// File: rtl/echo_detector_if.sv
// rtl/echo_detector_if.sv - sample stream, measurement control and result bundle
interface echo_detector_if
    import echo_detector_pkg::*;
#(
    parameter int N_BITS   = DEF_N_BITS,
    parameter int CNT_BITS = DEF_CNT_BITS
);
    logic                  we;
    logic [N_BITS-1:0]     data_in;
    logic                  start;
    logic [N_BITS-1:0]     threshold;
    logic [BLANK_BITS-1:0] blank_len;
    logic [CNT_BITS-1:0]   max_len;
    logic                  busy;
    logic                  done;
    logic                  timeout;
    logic [CNT_BITS-1:0]   tof;
    logic [N_BITS-1:0]     peak;

    // Sample source and measurement controller side
    modport master (
        output we, data_in, start, threshold, blank_len, max_len,
        input  busy, done, timeout, tof, peak
    );

    // Detector side
    modport slave (
        input  we, data_in, start, threshold, blank_len, max_len,
        output busy, done, timeout, tof, peak
    );
endinterface

// File: rtl/echo_detector_sample_counter.sv
// rtl/echo_detector_sample_counter.sv - saturating sample counter with synchronous clear
module sample_counter #(
    parameter int W = 24
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count
);
    logic [W-1:0] r_count;

    // Clear wins over enable; the count sticks at all-ones instead of wrapping
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/echo_detector.sv
// rtl/echo_detector.sv - threshold echo detector measuring time of flight and echo peak
module echo_detector
    import echo_detector_pkg::*;
#(
    parameter int N_BITS   = DEF_N_BITS,
    parameter int CNT_BITS = DEF_CNT_BITS
) (
    input  logic           clk,
    input  logic           rst,
    echo_detector_if.slave bus
);
    // Wide enough to compare the counter against blank_len without truncation
    localparam int CMP_BITS = ((CNT_BITS > BLANK_BITS) ? CNT_BITS : BLANK_BITS) + 1;

    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_BITS-1:0]   w_count;
    logic [N_BITS-1:0]     r_threshold;
    logic [BLANK_BITS-1:0] r_blank_len;
    logic [CNT_BITS-1:0]   r_max_len;
    logic [CNT_BITS-1:0]   r_tof;
    logic [N_BITS-1:0]     r_peak;
    logic                  r_done;
    logic                  r_timeout;

    logic                  w_start_ok;
    logic                  w_count_en;
    logic                  w_above;
    logic                  w_blank_end;
    logic                  w_expire;
    logic                  w_trigger;
    logic                  w_finish;
    logic                  w_timeout_hit;
    logic [CMP_BITS-1:0]   w_index_p1;

    assign w_start_ok  = (r_state == ST_IDLE) && bus.start;
    assign w_count_en  = bus.we && (r_state != ST_IDLE);
    assign w_above     = bus.data_in > r_threshold;
    // The current sample is the last blanked one when index + 1 reaches blank_len
    assign w_index_p1  = CMP_BITS'(w_count) + CMP_BITS'(1);
    assign w_blank_end = (w_index_p1 == CMP_BITS'(r_blank_len));
    // max_len of zero disables the timeout entirely
    assign w_expire    = (r_max_len != '0) && (w_count == (r_max_len - CNT_BITS'(1)));

    sample_counter #(
        .W (CNT_BITS)
    ) u_sample_counter (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clr   (w_start_ok),
        .i_en    (w_count_en),
        .o_count (w_count)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; a trigger takes precedence over timeout on the same sample
    always_comb begin
        w_state_next  = r_state;
        w_trigger     = 1'b0;
        w_finish      = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next = (bus.blank_len == '0) ? ST_SEARCH : ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (bus.we) begin
                    if (w_expire) begin
                        w_state_next  = ST_IDLE;
                        w_timeout_hit = 1'b1;
                    end else if (w_blank_end) begin
                        w_state_next = ST_SEARCH;
                    end
                end
            end
            ST_SEARCH: begin
                if (bus.we) begin
                    if (w_above) begin
                        w_state_next = ST_TRACK;
                        w_trigger    = 1'b1;
                    end else if (w_expire) begin
                        w_state_next  = ST_IDLE;
                        w_timeout_hit = 1'b1;
                    end
                end
            end
            ST_TRACK: begin
                if (bus.we && !w_above) begin
                    w_state_next = ST_IDLE;
                    w_finish     = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Configuration capture, result registers and exit pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_threshold <= '0;
            r_blank_len <= '0;
            r_max_len   <= '0;
            r_tof       <= '0;
            r_peak      <= '0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_done    <= w_finish;
            r_timeout <= w_timeout_hit;
            if (w_start_ok) begin
                r_threshold <= bus.threshold;
                r_blank_len <= bus.blank_len;
                r_max_len   <= bus.max_len;
                r_tof       <= '0;
                r_peak      <= '0;
            end else if (w_trigger) begin
                r_tof  <= w_count;
                r_peak <= bus.data_in;
            end else if ((r_state == ST_TRACK) && bus.we && (bus.data_in > r_peak)) begin
                r_peak <= bus.data_in;
            end
        end
    end

    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.done    = r_done;
    assign bus.timeout = r_timeout;
    assign bus.tof     = r_tof;
    assign bus.peak    = r_peak;
endmodule

// File: tb/tb_echo_detector.sv
// tb/tb_echo_detector.sv - directed self-checking bench for echo_detector
module tb_echo_detector;
    import echo_detector_pkg::*;

    localparam int N_BITS   = DEF_N_BITS;
    localparam int CNT_BITS = DEF_CNT_BITS;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    echo_detector_if #(.N_BITS(N_BITS), .CNT_BITS(CNT_BITS)) bus ();

    echo_detector #(
        .N_BITS   (N_BITS),
        .CNT_BITS (CNT_BITS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input int thr, input int blen, input int mlen);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.threshold = N_BITS'(thr);
        bus.blank_len = 16'(blen);
        bus.max_len   = CNT_BITS'(mlen);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic send(input int v);
        @(negedge clk);
        bus.we      = 1'b1;
        bus.data_in = N_BITS'(v);
        @(posedge clk);
        #1;
        bus.we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b0;
        bus.we        = 1'b0;
        bus.data_in   = '0;
        bus.start     = 1'b0;
        bus.threshold = '0;
        bus.blank_len = '0;
        bus.max_len   = '0;

        // reset state
        idle(3);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_timeout", bus.timeout, 0);
        check("rst_tof", bus.tof, 0);
        check("rst_peak", bus.peak, 0);
        @(negedge clk);
        rst = 1'b1;
        idle(1);

        // basic echo: blank 4, trigger at index 10, peak 300, ends at index 13
        do_start(100, 4, 1000);
        check("m1_busy_after_start", bus.busy, 1);
        for (int i = 0; i < 4; i++) send(200);
        check("m1_blank_ignored_peak", bus.peak, 0);
        for (int i = 4; i < 10; i++) send(50);
        check("m1_search_busy", bus.busy, 1);
        send(150);
        check("m1_tof_at_trigger", bus.tof, 10);
        check("m1_peak_at_trigger", bus.peak, 150);
        send(300);
        send(120);
        check("m1_peak_held", bus.peak, 300);
        check("m1_done_early", bus.done, 0);
        send(80);
        check("m1_done", bus.done, 1);
        check("m1_busy_end", bus.busy, 0);
        check("m1_tof", bus.tof, 10);
        check("m1_peak", bus.peak, 300);
        idle(1);
        check("m1_done_one_cycle", bus.done, 0);

        // timeout after index 15 with no echo
        do_start(100, 2, 16);
        check("m2_tof_cleared", bus.tof, 0);
        check("m2_peak_cleared", bus.peak, 0);
        for (int i = 0; i < 15; i++) send(50);
        check("m2_busy_before_expiry", bus.busy, 1);
        check("m2_timeout_early", bus.timeout, 0);
        send(50);
        check("m2_timeout", bus.timeout, 1);
        check("m2_busy_end", bus.busy, 0);
        check("m2_done", bus.done, 0);
        check("m2_tof", bus.tof, 0);
        check("m2_peak", bus.peak, 0);
        idle(1);
        check("m2_timeout_one_cycle", bus.timeout, 0);

        // equal-to-threshold does not trigger, max_len 0 never times out
        do_start(100, 0, 0);
        for (int i = 0; i < 20; i++) send(50);
        send(100);
        check("m3_equal_no_trigger", bus.tof, 0);
        check("m3_still_busy", bus.busy, 1);
        send(101);
        check("m3_tof", bus.tof, 21);
        check("m3_peak", bus.peak, 101);
        send(40);
        check("m3_done", bus.done, 1);
        check("m3_no_timeout", bus.timeout, 0);

        // start while busy ignored, we gaps freeze the counter
        do_start(100, 1, 0);
        send(50);
        send(50);
        do_start(10, 0, 0);
        check("m4_busy_ignored_start", bus.busy, 1);
        idle(3);
        send(120);
        check("m4_tof", bus.tof, 2);
        check("m4_peak", bus.peak, 120);
        send(5);
        check("m4_done", bus.done, 1);
        send(999);
        check("m4_idle_peak_held", bus.peak, 120);
        check("m4_idle_tof_held", bus.tof, 2);
        check("m4_idle_busy", bus.busy, 0);

        // reset during TRACK aborts immediately
        do_start(100, 0, 0);
        send(50);
        send(150);
        check("m5_track_busy", bus.busy, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("m5_rst_busy", bus.busy, 0);
        check("m5_rst_tof", bus.tof, 0);
        check("m5_rst_peak", bus.peak, 0);
        check("m5_rst_done", bus.done, 0);
        idle(1);
        @(negedge clk);
        rst = 1'b1;
        idle(1);
        check("m5_no_done_after_rst", bus.done, 0);
        do_start(100, 0, 0);
        send(50);
        send(50);
        send(130);
        check("m5_restart_tof", bus.tof, 2);
        send(90);
        check("m5_restart_done", bus.done, 1);

        // trigger on the last in-window sample wins over timeout
        do_start(100, 0, 8);
        for (int i = 0; i < 7; i++) send(50);
        send(200);
        check("m6_no_timeout_at_trigger", bus.timeout, 0);
        check("m6_busy_track", bus.busy, 1);
        for (int i = 8; i < 12; i++) send(150);
        check("m6_still_tracking", bus.busy, 1);
        send(60);
        check("m6_done", bus.done, 1);
        check("m6_timeout", bus.timeout, 0);
        check("m6_tof", bus.tof, 7);
        check("m6_peak", bus.peak, 200);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
